shared_res_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource, such as a priority-encoded datapath, between `N` requesters. It performs a registered, work-conserving handoff with a bounded hold time. Each requester holds a level request, and the block grants exactly one requester at a time. A grant is held until the owner drops its request or the hold limit expires. The block sits between the requester front-ends and the shared resource and drives the resource's select and valid.

---
 rtl/arb_pkg.sv | 9 +
 rtl/shared_res_arbiter_rr_pick.sv | 27 ++
 rtl/shared_res_arbiter.sv | 82 ++++++++
 tb/tb_shared_res_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared types, defaults and width helper for shared_res_arbiter.
package arb_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  localparam int DEF_N = 4;
  localparam int DEF_MAX_HOLD = 16;
  function automatic int clog2_safe(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/shared_res_arbiter_rr_pick.sv
// rr_pick: rotating priority encoder, first unmasked request after last.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = DEF_N,
  localparam int IW = clog2_safe(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx
);
  logic [N-1:0] cand;
  assign cand = req & ~mask;
  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      if (cand[(int'(last) + i) % N]) begin
        any = 1'b1;
        idx = IW'((int'(last) + i) % N);
      end
    end
  end
endmodule

// File: rtl/shared_res_arbiter.sv
// shared_res_arbiter: round-robin arbiter with bounded hold and registered grant.
module shared_res_arbiter
  import arb_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  localparam int IW = clog2_safe(N),
  localparam int CW = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          gnt_valid,
  output logic          expired
);
  arb_state_t state_q, state_d;
  logic [IW-1:0] id_q, id_d, last_q, last_d, pick_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic exp_q, exp_d, pick_any, owner_req, timeout;
  logic [N-1:0] mask;
  assign owner_req = (state_q == BUSY) && req[id_q];
  assign timeout = owner_req && (cnt_q >= CW'(MAX_HOLD));
  always_comb begin
    mask = '0;
    if (timeout) mask[id_q] = 1'b1;
  end
  rr_pick #(.N(N)) u_pick (
    .req (req),
    .mask(mask),
    .last(last_q),
    .any (pick_any),
    .idx (pick_idx)
  );
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    last_d = last_q;
    cnt_d = cnt_q;
    exp_d = 1'b0;
    if (owner_req && !timeout) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pick_any) begin
      state_d = BUSY;
      id_d = pick_idx;
      last_d = pick_idx;
      cnt_d = CW'(1);
      exp_d = timeout;
    end else if (timeout) begin
      // Sole requester timed out: re-grant the same owner.
      cnt_d = CW'(1);
      exp_d = 1'b1;
    end else begin
      state_d = IDLE;
      id_d = '0;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q <= '0;
      last_q <= IW'(N - 1);
      cnt_q <= '0;
      exp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      exp_q <= exp_d;
    end
  end
  always_comb begin
    gnt = '0;
    if (state_q == BUSY) gnt[id_q] = 1'b1;
  end
  assign gnt_id = id_q;
  assign gnt_valid = (state_q == BUSY);
  assign expired = exp_q;
endmodule

// File: tb/tb_shared_res_arbiter.sv
// tb_shared_res_arbiter: directed vectors with a queued scoreboard and per-cycle monitor.
module tb_shared_res_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic gnt_valid, expired;
  typedef struct {
    string name;
    logic [3:0] g;
    logic [1:0] id;
    logic v;
    logic x;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  shared_res_arbiter #(.N(4), .MAX_HOLD(16)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .gnt_valid(gnt_valid),
    .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg, input logic ex, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    e.name = nm;
    e.g = eg;
    e.id = 2'd0;
    for (int i = 0; i < 4; i++) if (eg[i]) e.id = 2'(i);
    e.v = |eg;
    e.x = ex;
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n, input logic [3:0] rq, input logic [3:0] eg, input string nm);
    for (int i = 0; i < n; i++) step(1'b0, rq, eg, 1'b0, nm);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({gnt, gnt_id, gnt_valid, expired} !== {e.g, e.id, e.v, e.x}) begin
        errors++;
        $display("FAIL %s: got gnt=%b id=%0d valid=%b expired=%b, want gnt=%b id=%0d valid=%b expired=%b",
                 e.name, gnt, gnt_id, gnt_valid, expired, e.g, e.id, e.v, e.x);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 4'b0000, 1'b0, "reset_hold");
    step(1'b0, 4'b1111, 4'b0001, 1'b0, "first_grant");
    step(1'b0, 4'b1111, 4'b0001, 1'b0, "rr_hold0");
    step(1'b0, 4'b1110, 4'b0010, 1'b0, "rr_to1");
    step(1'b0, 4'b1111, 4'b0010, 1'b0, "rr_hold1");
    step(1'b0, 4'b1101, 4'b0100, 1'b0, "rr_to2");
    step(1'b0, 4'b1111, 4'b0100, 1'b0, "rr_hold2");
    step(1'b0, 4'b1011, 4'b1000, 1'b0, "rr_to3");
    step(1'b0, 4'b1111, 4'b1000, 1'b0, "rr_hold3");
    step(1'b0, 4'b0111, 4'b0001, 1'b0, "rr_wrap0");
    step(1'b0, 4'b1111, 4'b0001, 1'b0, "rr_hold0b");
    step(1'b1, 4'b0011, 4'b0000, 1'b0, "reset_to");
    hold(16, 4'b0011, 4'b0001, "to_own0");
    step(1'b0, 4'b0011, 4'b0010, 1'b1, "to_hand1");
    hold(15, 4'b0011, 4'b0010, "to_own1");
    step(1'b0, 4'b0011, 4'b0001, 1'b1, "to_hand0");
    step(1'b0, 4'b0011, 4'b0001, 1'b0, "to_own0b");
    step(1'b1, 4'b0100, 4'b0000, 1'b0, "reset_sole");
    hold(16, 4'b0100, 4'b0100, "sole_own");
    step(1'b0, 4'b0100, 4'b0100, 1'b1, "sole_regrant1");
    hold(15, 4'b0100, 4'b0100, "sole_own2");
    step(1'b0, 4'b0100, 4'b0100, 1'b1, "sole_regrant2");
    step(1'b0, 4'b0100, 4'b0100, 1'b0, "sole_after");
    step(1'b1, 4'b0000, 4'b0000, 1'b0, "reset_idle");
    step(1'b0, 4'b1000, 4'b1000, 1'b0, "idle_gnt3");
    step(1'b0, 4'b0000, 4'b0000, 1'b0, "idle_release");
    step(1'b0, 4'b0000, 4'b0000, 1'b0, "idle_stay");
    step(1'b0, 4'b1001, 4'b0001, 1'b0, "idle_wrap0");
    step(1'b1, 4'b0100, 4'b0000, 1'b0, "reset_mid_pre");
    hold(7, 4'b0100, 4'b0100, "mid_own2");
    step(1'b1, 4'b0110, 4'b0000, 1'b0, "mid_reset");
    step(1'b0, 4'b0110, 4'b0010, 1'b0, "mid_regrant1");
    hold(15, 4'b0110, 4'b0010, "mid_own1");
    step(1'b0, 4'b0110, 4'b0100, 1'b1, "mid_hand2");
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
